lsu_16b: RTL and testbench
==========================

Name: lsu_16b

Overview:
- Load/store unit directly downstream of the 16-bit ALU.
- Takes the ALU's generated address and payload, then runs the memory transaction over the core's 8-bit external bus as one byte access (narrow) or two little-endian byte accesses (wide).
- Returns load data for register-file writeback and reports completion to the scheduler.
- Includes an ack watchdog that aborts hung accesses.

Parameters:
- ACK_TIMEOUT, 255: max cycles a byte access waits for mem_ack before aborting. 0 disables the watchdog. Legal range 0..255 (8-bit counter).

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  scheduler requests a transfer this cycle
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_wide  in  1  1 = 16-bit access, 0 = 8-bit access
- alu_adr  in  16  effective address (ALU address output)
- alu_payload  in  16  store data (ALU result output)
- mem_req  out  1  bus cycle active
- mem_we  out  1  bus write strobe
- mem_adr  out  16  bus byte address
- mem_dout  out  8  bus write data
- mem_din  in  8  bus read data, valid when mem_ack=1
- mem_ack  in  1  bus completes current byte access this cycle
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_err  out  1  qualifies rsp_valid: transfer aborted by watchdog
- ld_we  out  1  register-file write enable (rsp_valid & ~write & ~err)
- ld_data  out  16  load result; narrow loads zero-extended (sign extension is done by the ALU EXT op)

Behaviour:
- State machine: IDLE, LO, HI, DONE. All outputs decode from flops only (no input-to-output combinational path except req_ready ignoring inputs).
- Reset:
  - State goes to IDLE.
  - mem_req, mem_we, rsp_valid, rsp_err and ld_we are 0.
  - mem_adr, mem_dout, ld_data and internal address/payload/data registers are 0.
  - Watchdog counter is 0.
- Reset mid-operation:
  - The transfer is dropped; mem_req is low from the next cycle.
  - No rsp_valid is issued for the dropped transfer.
- IDLE:
  - req_ready = 1.
  - When req_valid = 1, latch alu_adr, alu_payload, req_write and req_wide, clear the data register, and go to LO.
  - The accept cycle is cycle 0.
- LO:
  - mem_req = 1, mem_adr = latched adr, mem_we = write, mem_dout = payload[7:0].
  - On mem_ack:
    - A load captures mem_din into data[7:0].
    - Go to HI if wide, else DONE.
- HI:
  - mem_req = 1, mem_adr = adr + 1 (16-bit wrap: 0xFFFF -> 0x0000), mem_dout = payload[15:8].
  - On mem_ack, a load captures mem_din into data[15:8]; go to DONE.
- Stall: without mem_ack, LO/HI hold every bus output stable.
- Watchdog:
  - The counter resets to 0 on entering LO or HI and increments each non-ack cycle.
  - When ACK_TIMEOUT != 0 and the counter reaches ACK_TIMEOUT with no ack, set err and go to DONE.
  - An ack arriving on the same cycle as the limit wins: no error.
- DONE:
  - rsp_valid = 1 for exactly one cycle; rsp_err = err; ld_we = ~write & ~err; ld_data = data.
  - Go to IDLE next.
  - ld_data holds its value until the next DONE.
- Latency, with ack in the first bus cycle:
  - Narrow: rsp_valid at cycle 2.
  - Wide: rsp_valid at cycle 3.
  - req_ready is next high in the cycle after DONE; throughput is one request per 3 (narrow) or 4 (wide) cycles minimum.
- Requests while req_ready = 0 are ignored; the scheduler must hold them.
- Stores leave ld_data unchanged.

Test Plan:
- Narrow load: adr=0x1234, wide=0, mem_din=0xA5 with immediate ack -> one bus cycle, mem_adr=0x1234, mem_we=0, rsp_valid and ld_we at cycle 2, ld_data=0x00A5.
- Wide store: adr=0x2000, payload=0xBEEF, ack after 3 wait cycles each byte -> writes 0xEF at 0x2000 then 0xBE at 0x2001; outputs stable during waits; rsp_valid=1, ld_we=0, ld_data unchanged.
- Wrap: wide load at 0xFFFF, din 0x34 then 0x12 -> second mem_adr=0x0000, ld_data=0x1234.
- Watchdog: ACK_TIMEOUT=4, no ack -> mem_req high 4 cycles then DONE with rsp_err=1, ld_we=0; repeat with ack on the 4th wait cycle -> rsp_err=0.
- Reset in HI of a wide load -> next cycle mem_req=0, req_ready=1, rsp_valid never asserted; following narrow load completes normally.
- Back-to-back: req_valid held high for two narrow loads -> second accepted the cycle after the first DONE; req_ready=0 throughout LO/DONE.

Source files
------------

// File: rtl/lsu_16b.sv
// Load/store unit: runs one narrow or two little-endian byte accesses over the 8-bit bus
// for each accepted request, with an ack watchdog that aborts hung byte accesses.
module lsu_16b #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_wide,
    input  logic [15:0] alu_adr,
    input  logic [15:0] alu_payload,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_adr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic        ld_we,
    output logic [15:0] ld_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [15:0] adr;
    logic [15:0] payload;
    logic [15:0] data;
    logic [15:0] ld_data_q;
    logic        is_write;
    logic        is_wide;
    logic        err;
    logic [7:0]  wd_cnt;
    logic        timeout;

    // The limit is hit on the wait cycle whose increment would make the count equal ACK_TIMEOUT.
    assign timeout = (ACK_TIMEOUT != 0) && (({1'b0, wd_cnt} + 9'd1) == 9'(ACK_TIMEOUT));

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            adr       <= '0;
            payload   <= '0;
            data      <= '0;
            ld_data_q <= '0;
            is_write  <= 1'b0;
            is_wide   <= 1'b0;
            err       <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        adr      <= alu_adr;
                        payload  <= alu_payload;
                        is_write <= req_write;
                        is_wide  <= req_wide;
                        data     <= '0;
                        err      <= 1'b0;
                        wd_cnt   <= '0;
                        state    <= S_LO;
                    end
                end
                S_LO: begin
                    if (mem_ack) begin
                        wd_cnt <= '0;
                        if (!is_write) data[7:0] <= mem_din;
                        if (is_wide) begin
                            state <= S_HI;
                        end else begin
                            state <= S_DONE;
                            if (!is_write) ld_data_q <= {data[15:8], mem_din};
                        end
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                        if (!is_write) ld_data_q <= data;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                S_HI: begin
                    if (mem_ack) begin
                        wd_cnt <= '0;
                        state  <= S_DONE;
                        if (!is_write) begin
                            data[15:8] <= mem_din;
                            ld_data_q  <= {mem_din, data[7:0]};
                        end
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                        if (!is_write) ld_data_q <= data;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state only; the bus address wraps naturally at 16 bits.
    assign req_ready = (state == S_IDLE);
    assign mem_req   = (state == S_LO) || (state == S_HI);
    assign mem_we    = mem_req && is_write;
    assign mem_adr   = (state == S_HI) ? (adr + 16'd1) : adr;
    assign mem_dout  = (state == S_HI) ? payload[15:8] : payload[7:0];
    assign rsp_valid = (state == S_DONE);
    assign rsp_err   = rsp_valid && err;
    assign ld_we     = rsp_valid && !is_write && !err;
    assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_lsu_16b.sv
// Directed self-checking bench for lsu_16b with a short watchdog limit (ACK_TIMEOUT=4).
module tb_lsu_16b;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_wide;
    logic [15:0] alu_adr;
    logic [15:0] alu_payload;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_adr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_ack;
    logic        rsp_valid;
    logic        rsp_err;
    logic        ld_we;
    logic [15:0] ld_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_16b #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_wide(req_wide),
        .alu_adr(alu_adr), .alu_payload(alu_payload),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_ack(mem_ack),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .ld_we(ld_we), .ld_data(ld_data)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns so sampling and driving stay off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic wd, input logic [15:0] a, input logic [15:0] p);
        req_valid = 1'b1; req_write = wr; req_wide = wd; alu_adr = a; alu_payload = p;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0;
        alu_adr = '0; alu_payload = '0; mem_din = '0; mem_ack = 1'b0;
        step(); step();
        check("rst_ready", 16'(req_ready), 16'd1);
        check("rst_mem_req", 16'(mem_req), 16'd0);
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_ld_data", ld_data, 16'h0000);
        check("rst_mem_adr", mem_adr, 16'h0000);
        rst = 1'b0;
        step();

        // Narrow load, immediate ack
        issue(1'b0, 1'b0, 16'h1234, 16'h0000);
        check("nl_mem_req", 16'(mem_req), 16'd1);
        check("nl_mem_adr", mem_adr, 16'h1234);
        check("nl_mem_we", 16'(mem_we), 16'd0);
        check("nl_ready_lo", 16'(req_ready), 16'd0);
        check("nl_rsp_early", 16'(rsp_valid), 16'd0);
        mem_ack = 1'b1; mem_din = 8'hA5;
        step();
        mem_ack = 1'b0;
        check("nl_rsp_valid", 16'(rsp_valid), 16'd1);
        check("nl_ld_we", 16'(ld_we), 16'd1);
        check("nl_rsp_err", 16'(rsp_err), 16'd0);
        check("nl_ld_data", ld_data, 16'h00A5);
        check("nl_mem_req_done", 16'(mem_req), 16'd0);
        step();
        check("nl_rsp_pulse", 16'(rsp_valid), 16'd0);
        check("nl_ready_after", 16'(req_ready), 16'd1);
        check("nl_ld_hold", ld_data, 16'h00A5);

        // Wide store with 3 wait cycles per byte
        issue(1'b1, 1'b1, 16'h2000, 16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            check("ws_lo_req", 16'(mem_req), 16'd1);
            check("ws_lo_we", 16'(mem_we), 16'd1);
            check("ws_lo_adr", mem_adr, 16'h2000);
            check("ws_lo_dout", 16'(mem_dout), 16'h00EF);
            mem_ack = (i == 3);
            step();
        end
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ws_hi_req", 16'(mem_req), 16'd1);
            check("ws_hi_we", 16'(mem_we), 16'd1);
            check("ws_hi_adr", mem_adr, 16'h2001);
            check("ws_hi_dout", 16'(mem_dout), 16'h00BE);
            mem_ack = (i == 3);
            step();
        end
        mem_ack = 1'b0;
        check("ws_rsp_valid", 16'(rsp_valid), 16'd1);
        check("ws_rsp_err", 16'(rsp_err), 16'd0);
        check("ws_ld_we", 16'(ld_we), 16'd0);
        check("ws_ld_data", ld_data, 16'h00A5);
        step();

        // Wide load wrapping from 0xFFFF to 0x0000
        issue(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        check("wr_lo_adr", mem_adr, 16'hFFFF);
        mem_ack = 1'b1; mem_din = 8'h34;
        step();
        check("wr_hi_req", 16'(mem_req), 16'd1);
        check("wr_hi_adr", mem_adr, 16'h0000);
        check("wr_no_rsp", 16'(rsp_valid), 16'd0);
        mem_din = 8'h12;
        step();
        mem_ack = 1'b0;
        check("wr_rsp_valid", 16'(rsp_valid), 16'd1);
        check("wr_ld_we", 16'(ld_we), 16'd1);
        check("wr_ld_data", ld_data, 16'h1234);
        step();

        // Watchdog abort: no ack for 4 cycles
        issue(1'b0, 1'b0, 16'h0010, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            check("wd_req_held", 16'(mem_req), 16'd1);
            step();
        end
        check("wd_rsp_valid", 16'(rsp_valid), 16'd1);
        check("wd_rsp_err", 16'(rsp_err), 16'd1);
        check("wd_ld_we", 16'(ld_we), 16'd0);
        step();

        // Ack on the 4th wait cycle wins over the watchdog
        issue(1'b0, 1'b0, 16'h0020, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            check("wa_req_held", 16'(mem_req), 16'd1);
            mem_ack = (i == 3); mem_din = 8'h5C;
            step();
        end
        mem_ack = 1'b0;
        check("wa_rsp_valid", 16'(rsp_valid), 16'd1);
        check("wa_rsp_err", 16'(rsp_err), 16'd0);
        check("wa_ld_we", 16'(ld_we), 16'd1);
        check("wa_ld_data", ld_data, 16'h005C);
        step();

        // Reset during the high byte of a wide load
        issue(1'b0, 1'b1, 16'h4000, 16'h0000);
        mem_ack = 1'b1; mem_din = 8'h77;
        step();
        mem_ack = 1'b0;
        check("rh_in_hi", 16'(mem_req), 16'd1);
        check("rh_hi_adr", mem_adr, 16'h4001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rh_mem_req", 16'(mem_req), 16'd0);
        check("rh_ready", 16'(req_ready), 16'd1);
        check("rh_rsp", 16'(rsp_valid), 16'd0);
        for (int i = 0; i < 3; i++) begin
            check("rh_no_rsp", 16'(rsp_valid), 16'd0);
            step();
        end
        issue(1'b0, 1'b0, 16'h0042, 16'h0000);
        check("rh_nl_adr", mem_adr, 16'h0042);
        mem_ack = 1'b1; mem_din = 8'h3C;
        step();
        mem_ack = 1'b0;
        check("rh_nl_rsp", 16'(rsp_valid), 16'd1);
        check("rh_nl_data", ld_data, 16'h003C);
        step();

        // Back-to-back narrow loads with req_valid and mem_ack held high
        req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b0; alu_adr = 16'h0100;
        mem_ack = 1'b1; mem_din = 8'h11;
        step();
        check("bb_ready_lo1", 16'(req_ready), 16'd0);
        check("bb_req_lo1", 16'(mem_req), 16'd1);
        check("bb_adr_lo1", mem_adr, 16'h0100);
        alu_adr = 16'h0200;
        step();
        check("bb_ready_done1", 16'(req_ready), 16'd0);
        check("bb_rsp1", 16'(rsp_valid), 16'd1);
        check("bb_data1", ld_data, 16'h0011);
        mem_din = 8'h22;
        step();
        check("bb_ready_idle", 16'(req_ready), 16'd1);
        check("bb_idle_no_rsp", 16'(rsp_valid), 16'd0);
        check("bb_idle_no_req", 16'(mem_req), 16'd0);
        step();
        req_valid = 1'b0;
        check("bb_ready_lo2", 16'(req_ready), 16'd0);
        check("bb_adr_lo2", mem_adr, 16'h0200);
        step();
        mem_ack = 1'b0;
        check("bb_rsp2", 16'(rsp_valid), 16'd1);
        check("bb_data2", ld_data, 16'h0022);
        step();
        check("bb_end_ready", 16'(req_ready), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
